// File: rtl/hack_pkg.sv
// Shared Hack instruction field layout and jump encodings.
// Used by hack_cpu for decode.
package hack_pkg;

  localparam int TYPE_BIT = 15;
  localparam int A_BIT    = 12;
  localparam int COMP_LSB = 6;
  localparam int COMP_W   = 6;
  localparam int DEST_LSB = 3;
  localparam int DEST_W   = 3;
  localparam int JUMP_LSB = 0;
  localparam int JUMP_W   = 3;

  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } comp_t;

  typedef struct packed {
    logic a;
    logic d;
    logic m;
  } dest_t;

  typedef enum logic [JUMP_W-1:0] {
    JNONE = 3'b000,
    JGT   = 3'b001,
    JEQ   = 3'b010,
    JGE   = 3'b011,
    JLT   = 3'b100,
    JNE   = 3'b101,
    JLE   = 3'b110,
    JMP   = 3'b111
  } jump_e;

endpackage

// File: rtl/alu.sv
// Hack ALU: x/y zero and negate, add or and, negate output.
// zr/ng flags describe the final result.
module alu (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        zx,
  input  logic        nx,
  input  logic        zy,
  input  logic        ny,
  input  logic        f,
  input  logic        no,
  output logic [15:0] out,
  output logic        zr,
  output logic        ng
);

  logic [15:0] x1, x2, y1, y2, r;

  // Operand conditioning, function select and output negate.
  always_comb begin
    x1  = zx ? 16'h0000 : x;
    x2  = nx ? ~x1 : x1;
    y1  = zy ? 16'h0000 : y;
    y2  = ny ? ~y1 : y1;
    r   = f ? (x2 + y2) : (x2 & y2);
    out = no ? ~r : r;
    zr  = (out == 16'h0000);
    ng  = out[15];
  end

endmodule

// File: rtl/hack_cpu.sv
// Single-cycle Hack CPU: A/D registers, decode, PC, ALU instance.
// Optional debug ports enabled by defining HACK_CPU_DEBUG_EN.
module hack_cpu
  import hack_pkg::*;
#(
  parameter logic [14:0] RESET_VECTOR = 15'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instruction,
  input  logic [15:0] inM,
  output logic [15:0] outM,
  output logic        writeM,
  output logic [14:0] addressM,
  output logic [14:0] pc
`ifdef HACK_CPU_DEBUG_EN
  ,
  output logic [15:0] dbg_a,
  output logic [15:0] dbg_d,
  output logic [31:0] dbg_retired
`endif
);

  logic [15:0] a_q, d_q;
  logic [14:0] pc_q;
  logic        is_c;
  comp_t       comp;
  dest_t       dest;
  jump_e       jsel;
  logic [15:0] y_op, alu_out;
  logic        zr, ng, jump;

  assign is_c = instruction[TYPE_BIT];
  assign comp = comp_t'(instruction[COMP_LSB +: COMP_W]);
  assign dest = dest_t'(instruction[DEST_LSB +: DEST_W]);
  assign jsel = jump_e'(instruction[JUMP_LSB +: JUMP_W]);
  assign y_op = instruction[A_BIT] ? inM : a_q;

  alu u_alu (
    .x   (d_q),
    .y   (y_op),
    .zx  (comp.zx),
    .nx  (comp.nx),
    .zy  (comp.zy),
    .ny  (comp.ny),
    .f   (comp.f),
    .no  (comp.no),
    .out (alu_out),
    .zr  (zr),
    .ng  (ng)
  );

  // Jump condition from ALU flags; A-instructions never jump.
  always_comb begin
    jump = 1'b0;
    unique case (jsel)
      JNONE: jump = 1'b0;
      JGT:   jump = ~ng & ~zr;
      JEQ:   jump = zr;
      JGE:   jump = ~ng;
      JLT:   jump = ng;
      JNE:   jump = ~zr;
      JLE:   jump = ng | zr;
      JMP:   jump = 1'b1;
    endcase
    if (!is_c) jump = 1'b0;
  end

  assign outM     = alu_out;
  assign writeM   = is_c & dest.m & ~reset;
  assign addressM = a_q[14:0];
  assign pc       = pc_q;

  // Architectural state; jump target uses A from before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q  <= 16'h0000;
      d_q  <= 16'h0000;
      pc_q <= RESET_VECTOR;
    end else begin
      if (!is_c)
        a_q <= instruction;
      else if (dest.a)
        a_q <= alu_out;
      if (is_c && dest.d)
        d_q <= alu_out;
      pc_q <= jump ? a_q[14:0] : pc_q + 15'd1;
    end
  end

`ifdef HACK_CPU_DEBUG_EN
  logic [31:0] retired_q;

  // Retired-instruction counter, one per non-reset edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) retired_q <= 32'd0;
    else       retired_q <= retired_q + 32'd1;
  end

  assign dbg_a       = a_q;
  assign dbg_d       = d_q;
  assign dbg_retired = retired_q;
`endif

endmodule

// File: doc/hack_cpu.md
HACK_CPU -- requirements
Module: hack_cpu

Interface
REQ-001 Parameter: RESET_VECTOR, default 15'h0000, PC value loaded on reset.
REQ-002 The design SHALL use one clock and an asynchronous, active-high reset.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: reset  input  1  asynchronous active-high reset.
REQ-005 Port: instruction  input  16  instruction fetched at address pc.
REQ-006 Port: inM  input  16  data memory read value at addressM.
REQ-007 Port: outM  output  16  ALU result, the data memory write value.
REQ-008 Port: writeM  output  1  data memory write strobe for the current cycle.
REQ-009 Port: addressM  output  15  data memory address, equal to A[14:0].
REQ-010 Port: pc  output  15  instruction memory address.

Function
REQ-011 Each clock cycle SHALL execute exactly one instruction (single-cycle, no stalls).
REQ-012 An A-instruction (instruction[15]=0) SHALL load A <= instruction, leave D and PC+1 semantics unchanged, and hold writeM=0.
REQ-013 A C-instruction (instruction[15]=1) SHALL ignore bits 14:13.
REQ-014 For a C-instruction, bit12 (a) SHALL select the ALU y operand: 0 gives A, 1 gives inM. The x operand SHALL always be D.
REQ-015 ALU controls SHALL map as zx,nx,zy,ny,f,no = instruction[11:6].
REQ-016 ALU arithmetic SHALL be 16-bit two's complement, with wrap on overflow.
REQ-017 Destination bits d1,d2,d3 = instruction[5:3] SHALL enable writes to A, D and M respectively.
REQ-018 All three destinations MAY be written in the same cycle.
REQ-019 outM SHALL be combinational from the current A, D, inM and instruction.
REQ-020 writeM SHALL be combinational: instruction[15] & instruction[3].
REQ-021 addressM SHALL reflect A before the edge, so a write with d1=d3=1 stores to the old address.
REQ-022 Jump bits j1,j2,j3 = instruction[2:0] SHALL define jump = (j1&ng)|(j2&zr)|(j3&~ng&~zr), using the ALU zr/ng flags. jump SHALL be forced to 0 for A-instructions.
REQ-023 When jump=1, the next pc SHALL be the old A[14:0], even if the same instruction writes A. Otherwise the next pc SHALL be pc+1.
REQ-024 pc SHALL wrap from 15'h7FFF to 15'h0000.
REQ-025 jjj=111 SHALL jump unconditionally. jjj=000 SHALL never jump.

Reset
REQ-026 Asserting reset SHALL immediately force A=0, D=0 and pc=RESET_VECTOR.
REQ-027 While reset is high, the registers SHALL hold their reset values, and writeM SHALL be 0 regardless of instruction.
REQ-028 After deassertion, the first rising edge SHALL execute the instruction at RESET_VECTOR.
REQ-029 Reset asserted mid-instruction SHALL abort that instruction: no register update and no memory write.

Configuration
REQ-030 With macro HACK_CPU_DEBUG_EN defined, the block SHALL add three output ports:
  - dbg_a  output  16  current A value.
  - dbg_d  output  16  current D value.
  - dbg_retired  output  32  instructions executed since reset; resets to 0, increments once per non-reset edge, wraps at 2^32.
REQ-031 Without HACK_CPU_DEBUG_EN, the ports and the counter SHALL be absent, and behaviour SHALL be otherwise identical.

Structure
REQ-032 A shared package hack_pkg SHALL hold instruction field positions and widths (type bit, a bit, comp, dest, jump) and the jump encoding constants (JNONE=000 through JMP=111).
REQ-033 The existing ALU SHALL be instantiated unmodified as sub-module alu. Register, decode and PC logic SHALL stay in hack_cpu.

Verification
REQ-034 The bench SHALL cover each of the following directed scenarios:
  - Reset then release: pc=0, A=0, D=0, writeM=0. The first edge gives pc=1.
  - @5 (16'h0005) then D=A (16'hEC10): D=5, pc=2, writeM=0.
  - D=5, @100, M=D+1 (16'hE7C8): writeM=1, addressM=100, outM=6 in that cycle.
  - A=7, D=0, D;JEQ (16'hE302): pc=7. Repeat with D=3: pc advances by 1.
  - A=20, instruction AM=A+1;JMP (16'hEDEF) in one cycle: writes M[20]=21, A becomes 21, pc=20.
  - pc=15'h7FFF with an A-instruction: pc wraps to 0. Assert reset asynchronously mid-cycle: A, D and pc clear with no clock edge, and writeM drops to 0.
